// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer port arbiter: geometry,
// owner encoding and the in-flight read tag.
package fb_pkg;

  localparam int FB_ADDR_W       = 12;
  localparam int FB_DATA_W       = 24;
  localparam int FB_STARVE_LIMIT = 8;

  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef struct packed {
    logic vld;
    logic owner;
    logic is_read;
  } rd_tag_t;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Two-stage in-flight tag shift register. Stage p1 lines up with the RAM
// command and stage p2 with mem_rdata; p2 steers the owner's rdata load.
module fb_rd_tag_pipe
  import fb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic tag_vld_i,
  input  logic tag_owner_i,
  input  logic tag_rd_i,
  output logic host_load_o,
  output logic disp_load_o
);

  rd_tag_t tag_p1_q;
  rd_tag_t tag_p2_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tag_p1_q <= '0;
      tag_p2_q <= '0;
    end else begin
      tag_p1_q <= '{vld: tag_vld_i, owner: tag_owner_i, is_read: tag_rd_i};
      tag_p2_q <= tag_p1_q;
    end
  end

  // Writes travel as valid tags but never load read data.
  assign host_load_o = tag_p2_q.vld && tag_p2_q.is_read && (tag_p2_q.owner == OWN_HOST);
  assign disp_load_o = tag_p2_q.vld && tag_p2_q.is_read && (tag_p2_q.owner == OWN_DISP);

endmodule

// File: rtl/fb_port_arbiter.sv
// Arbitrates one single-port framebuffer RAM between the host port and the
// display fetch: display-first priority with a host starvation guard.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int STARVE_LIMIT = FB_STARVE_LIMIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic BOOST_EN = (STARVE_LIMIT > 0);

  logic              host_win;
  logic              disp_win;
  logic              boost;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              host_rvalid_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              disp_rvalid_q;
  logic [DATA_W-1:0] disp_rdata_q;
  logic              host_load;
  logic              disp_load;

  // Cycle N: grant and next-state. The host only wins a contended cycle
  // once it has been refused STARVE_LIMIT times in a row.
  always_comb begin
    boost       = BOOST_EN && (wait_cnt_q == LIMIT_C);
    disp_win    = disp_req && !(host_req && boost);
    host_win    = host_req && !disp_win;

    wait_cnt_d  = wait_cnt_q;
    if (!host_req || host_win) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT_C) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    mem_en_d    = host_win || disp_win;
    mem_we_d    = host_win && host_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (host_win) begin
      mem_addr_d = host_addr;
      if (host_we) begin
        mem_wdata_d = host_wdata;
      end
    end else if (disp_win) begin
      mem_addr_d = disp_addr;
    end
  end

  // Cycle N+1: registered RAM command.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wait_cnt_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  fb_rd_tag_pipe u_tag_pipe (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .tag_vld_i   (host_win || disp_win),
    .tag_owner_i (host_win ? OWN_HOST : OWN_DISP),
    .tag_rd_i    (host_win ? !host_we : disp_win),
    .host_load_o (host_load),
    .disp_load_o (disp_load)
  );

  // Cycle N+3: capture returned data into the owner's register only.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      disp_rvalid_q <= 1'b0;
      disp_rdata_q  <= '0;
    end else begin
      host_rvalid_q <= host_load;
      disp_rvalid_q <= disp_load;
      if (host_load) begin
        host_rdata_q <= mem_rdata;
      end
      if (disp_load) begin
        disp_rdata_q <= mem_rdata;
      end
    end
  end

  assign host_ack    = host_win;
  assign disp_ack    = disp_win;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign disp_rvalid = disp_rvalid_q;
  assign disp_rdata  = disp_rdata_q;

endmodule
